multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 72 +++++++
 rtl/multicycle_ctrl_if.sv | 44 ++++
 rtl/ctrl_decode.sv | 74 +++++++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle MIPS-subset controller: state codes,
// opcode/func encodings, ALU and PC-select codes, and the decode record.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EX  = 3'b010,
      S_MEM = 3'b011,
      S_WB  = 3'b100
   } state_t;

   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;

   localparam logic [1:0] PCS_PC4    = 2'b00;
   localparam logic [1:0] PCS_BRANCH = 2'b01;
   localparam logic [1:0] PCS_RS     = 2'b10;
   localparam logic [1:0] PCS_JUMP   = 2'b11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_BRANCH,
      CLS_J,
      CLS_JAL,
      CLS_JR,
      CLS_LW,
      CLS_SW,
      CLS_ILLEGAL
   } iclass_t;

   typedef struct packed {
      iclass_t    cls;
      logic [3:0] aluc;
      logic       alumm;
      logic       shift;
      logic       sext;
      logic       regrt;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. With CTRL_RETIRE_CNT_EN defined the bundle
// also carries the 32-bit retire counter.
interface multicycle_ctrl_if;
   logic [5:0]  op;
   logic [5:0]  func;
   logic        zero;
   logic        mem_ack;
   logic [1:0]  pcsource;
   logic        alumm;
   logic        shift;
   logic        mtoreg;
   logic        jal;
   logic [3:0]  aluc;
   logic        regrt;
   logic        sext;
   logic        ir_we;
   logic        pc_we;
   logic        wreg;
   logic        wmem;
   logic        mem_req;
   logic        illegal;
   logic [2:0]  state;
`ifdef CTRL_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   modport master (
      input  op, func, zero, mem_ack,
      output pcsource, alumm, shift, mtoreg, jal, aluc, regrt, sext,
      output ir_we, pc_we, wreg, wmem, mem_req, illegal, state
`ifdef CTRL_RETIRE_CNT_EN
      , output retire_cnt
`endif
   );

   modport slave (
      output op, func, zero, mem_ack,
      input  pcsource, alumm, shift, mtoreg, jal, aluc, regrt, sext,
      input  ir_we, pc_we, wreg, wmem, mem_req, illegal, state
`ifdef CTRL_RETIRE_CNT_EN
      , input retire_cnt
`endif
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: latched op/func -> class and ALU selects.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output dec_t       dec
);

   always_comb begin
      dec.cls     = CLS_ILLEGAL;
      dec.aluc    = ALUC_ADD;
      dec.alumm   = 1'b0;
      dec.shift   = 1'b0;
      dec.sext    = 1'b0;
      dec.regrt   = 1'b0;
      dec.illegal = 1'b1;
      case (op)
         OP_RTYPE: begin
            dec.cls     = CLS_ALU;
            dec.illegal = 1'b0;
            case (func)
               FN_ADD: dec.aluc = ALUC_ADD;
               FN_SUB: dec.aluc = ALUC_SUB;
               FN_AND: dec.aluc = ALUC_AND;
               FN_OR:  dec.aluc = ALUC_OR;
               FN_XOR: dec.aluc = ALUC_XOR;
               FN_SLL: begin dec.aluc = ALUC_SLL; dec.shift = 1'b1; end
               FN_SRL: begin dec.aluc = ALUC_SRL; dec.shift = 1'b1; end
               FN_SRA: begin dec.aluc = ALUC_SRA; dec.shift = 1'b1; end
               FN_JR:  dec.cls = CLS_JR;
               default: begin
                  dec.cls     = CLS_ILLEGAL;
                  dec.illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            dec.cls     = CLS_ALU;
            dec.illegal = 1'b0;
            dec.alumm   = 1'b1;
            dec.regrt   = 1'b1;
            case (op)
               OP_ADDI: begin dec.aluc = ALUC_ADD; dec.sext = 1'b1; end
               OP_ANDI: dec.aluc = ALUC_AND;
               OP_ORI:  dec.aluc = ALUC_OR;
               OP_XORI: dec.aluc = ALUC_XOR;
               default: dec.aluc = ALUC_LUI;
            endcase
         end
         OP_LW, OP_SW: begin
            dec.cls     = (op == OP_LW) ? CLS_LW : CLS_SW;
            dec.illegal = 1'b0;
            dec.alumm   = 1'b1;
            dec.sext    = 1'b1;
            dec.regrt   = (op == OP_LW);
         end
         OP_BEQ, OP_BNE: begin
            dec.cls     = CLS_BRANCH;
            dec.illegal = 1'b0;
         end
         OP_J: begin
            dec.cls     = CLS_J;
            dec.illegal = 1'b0;
         end
         OP_JAL: begin
            dec.cls     = CLS_JAL;
            dec.illegal = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM. Defining CTRL_RETIRE_CNT_EN adds a
// free-running count of cycles with pc_we asserted.
//
// state | meaning
// IF    | load IR, latch op/func
// ID    | decode latched instruction
// EX    | ALU setup, or resolve branch/jump/illegal and retire
// MEM   | hold mem_req until mem_ack
// WB    | register write and retire
module multicycle_ctrl
   import ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   state_t     state_q, state_d;
   logic [5:0] op_q, func_q;
   logic       rst_hold;
   logic       ack;
   logic       taken;
   dec_t       dec;

   logic [1:0] pcsource_c;
   logic [3:0] aluc_c;
   logic       alumm_c, shift_c, mtoreg_c, jal_c, regrt_c, sext_c;
   logic       ir_we_c, pc_we_c, wreg_c, wmem_c, mem_req_c, illegal_c;

   ctrl_decode u_decode (
      .op   (op_q),
      .func (func_q),
      .dec  (dec)
   );

   // reset wins over a same-cycle memory acknowledge
   assign ack   = bus.mem_ack & ~rst;
   assign taken = (op_q == OP_BNE) ? ~bus.zero : bus.zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IF;
         rst_hold <= 1'b1;
      end else begin
         state_q  <= state_d;
         rst_hold <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         func_q <= '0;
      end else if (ir_we_c) begin
         op_q   <= bus.op;
         func_q <= bus.func;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!rst_hold) begin
         case (state_q)
            S_IF: state_d = S_ID;
            S_ID: state_d = S_EX;
            S_EX: begin
               case (dec.cls)
                  CLS_ALU:        state_d = S_WB;
                  CLS_LW, CLS_SW: state_d = S_MEM;
                  default:        state_d = S_IF;
               endcase
            end
            S_MEM: if (ack) state_d = (dec.cls == CLS_LW) ? S_WB : S_IF;
            default: state_d = S_IF;
         endcase
      end
   end

   // outputs stay low for the cycle after a sampled reset
   always_comb begin
      pcsource_c = PCS_PC4;
      aluc_c     = ALUC_ADD;
      alumm_c    = 1'b0;
      shift_c    = 1'b0;
      mtoreg_c   = 1'b0;
      jal_c      = 1'b0;
      regrt_c    = 1'b0;
      sext_c     = 1'b0;
      ir_we_c    = 1'b0;
      pc_we_c    = 1'b0;
      wreg_c     = 1'b0;
      wmem_c     = 1'b0;
      mem_req_c  = 1'b0;
      illegal_c  = 1'b0;
      if (!rst_hold) begin
         case (state_q)
            S_IF: ir_we_c = 1'b1;
            S_EX: begin
               illegal_c = dec.illegal;
               case (dec.cls)
                  CLS_ALU, CLS_LW, CLS_SW: begin
                     aluc_c  = dec.aluc;
                     alumm_c = dec.alumm;
                     shift_c = dec.shift;
                     sext_c  = dec.sext;
                     regrt_c = dec.regrt;
                  end
                  CLS_BRANCH: begin
                     aluc_c     = ALUC_SUB;
                     pcsource_c = taken ? PCS_BRANCH : PCS_PC4;
                     pc_we_c    = 1'b1;
                  end
                  CLS_J: begin
                     pcsource_c = PCS_JUMP;
                     pc_we_c    = 1'b1;
                  end
                  CLS_JAL: begin
                     pcsource_c = PCS_JUMP;
                     jal_c      = 1'b1;
                     wreg_c     = 1'b1;
                     pc_we_c    = 1'b1;
                  end
                  CLS_JR: begin
                     pcsource_c = PCS_RS;
                     pc_we_c    = 1'b1;
                  end
                  default: pc_we_c = 1'b1;
               endcase
            end
            S_MEM: begin
               mem_req_c = 1'b1;
               wmem_c    = (dec.cls == CLS_SW);
               pc_we_c   = (dec.cls == CLS_SW) & ack;
            end
            S_WB: begin
               wreg_c   = 1'b1;
               pc_we_c  = 1'b1;
               regrt_c  = dec.regrt;
               mtoreg_c = (dec.cls == CLS_LW);
            end
            default: ;
         endcase
      end
   end

   assign bus.pcsource = pcsource_c;
   assign bus.aluc     = aluc_c;
   assign bus.alumm    = alumm_c;
   assign bus.shift    = shift_c;
   assign bus.mtoreg   = mtoreg_c;
   assign bus.jal      = jal_c;
   assign bus.regrt    = regrt_c;
   assign bus.sext     = sext_c;
   assign bus.ir_we    = ir_we_c;
   assign bus.pc_we    = pc_we_c;
   assign bus.wreg     = wreg_c;
   assign bus.wmem     = wmem_c;
   assign bus.mem_req  = mem_req_c;
   assign bus.illegal  = illegal_c;
   assign bus.state    = state_q;

`ifdef CTRL_RETIRE_CNT_EN
   logic [31:0] retire_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)          retire_cnt_q <= '0;
      else if (pc_we_c) retire_cnt_q <= retire_cnt_q + 32'd1;
   end

   assign bus.retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random
// instruction streams compared against a per-instruction cycle model.
module tb_multicycle_ctrl;

   typedef enum int {K_ALU, K_BR, K_J, K_JAL, K_JR, K_LW, K_SW, K_ILL} kind_e;

   typedef struct {
      logic [5:0] op;
      logic [5:0] func;
      kind_e      kind;
      logic [3:0] aluc;
      logic       alumm;
      logic       shift;
      logic       sext;
      logic       regrt;
   } ent_t;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] pcs;
      logic       alumm;
      logic       shift;
      logic       mtoreg;
      logic       jal;
      logic [3:0] aluc;
      logic       regrt;
      logic       sext;
      logic       ir_we;
      logic       pc_we;
      logic       wreg;
      logic       wmem;
      logic       mem_req;
      logic       illegal;
   } outs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   model_cnt = 0;
   ent_t tbl[$];
   outs_t obs;

   multicycle_ctrl_if bus_if ();

   multicycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   assign obs = {bus_if.state, bus_if.pcsource, bus_if.alumm, bus_if.shift,
                 bus_if.mtoreg, bus_if.jal, bus_if.aluc, bus_if.regrt,
                 bus_if.sext, bus_if.ir_we, bus_if.pc_we, bus_if.wreg,
                 bus_if.wmem, bus_if.mem_req, bus_if.illegal};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic add_ent(input logic [5:0] op, input logic [5:0] func, input kind_e kind,
                          input logic [3:0] aluc, input logic alumm, input logic shift,
                          input logic sext, input logic regrt);
      ent_t t;
      t.op = op; t.func = func; t.kind = kind; t.aluc = aluc;
      t.alumm = alumm; t.shift = shift; t.sext = sext; t.regrt = regrt;
      tbl.push_back(t);
   endtask

   function automatic int find(input logic [5:0] op, input logic [5:0] func);
      for (int i = 0; i < tbl.size(); i++)
         if (tbl[i].op == op && (op != 6'h00 || tbl[i].func == func)) return i;
      return -1;
   endfunction

   // one clock: drive at the falling edge, compare 1 time unit later
   task automatic step(input string tag, input outs_t e, input logic [5:0] op,
                       input logic [5:0] func, input logic z, input logic ack, input logic r);
      @(negedge clk);
      bus_if.op = op;
      bus_if.func = func;
      bus_if.zero = z;
      bus_if.mem_ack = ack;
      rst = r;
      #1;
`ifdef CTRL_RETIRE_CNT_EN
      chk({tag, ".retire_cnt"}, bus_if.retire_cnt, 32'(model_cnt));
`endif
      chk(tag, 32'(obs), 32'(e));
      if (r) model_cnt = 0;
      else if (e.pc_we) model_cnt++;
   endtask

   // rst_mem = k asserts reset on the k-th MEM cycle (0 = never)
   task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input logic z,
                            input int n_mem, input int rst_mem);
      int    idx;
      ent_t  en;
      kind_e k;
      outs_t e;
      logic  last, rs;
      idx = find(op, func);
      if (idx >= 0) en = tbl[idx];
      else begin
         en.op = op; en.func = func; en.kind = K_ILL; en.aluc = 4'b0000;
         en.alumm = 1'b0; en.shift = 1'b0; en.sext = 1'b0; en.regrt = 1'b0;
      end
      k = en.kind;

      e = '0; e.ir_we = 1'b1;
      step("IF", e, op, func, 1'($urandom), 1'($urandom), 1'b0);
      e = '0; e.st = 3'd1;
      step("ID", e, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);

      e = '0; e.st = 3'd2;
      case (k)
         K_ALU, K_LW, K_SW: begin
            e.aluc = en.aluc; e.alumm = en.alumm; e.shift = en.shift;
            e.sext = en.sext; e.regrt = en.regrt;
         end
         K_BR: begin
            e.aluc = 4'b0100; e.pc_we = 1'b1;
            e.pcs = (((en.op == 6'h04) ? z : !z) ? 2'b01 : 2'b00);
         end
         K_J:   begin e.pcs = 2'b11; e.pc_we = 1'b1; end
         K_JAL: begin e.pcs = 2'b11; e.pc_we = 1'b1; e.jal = 1'b1; e.wreg = 1'b1; end
         K_JR:  begin e.pcs = 2'b10; e.pc_we = 1'b1; end
         default: begin e.illegal = 1'b1; e.pc_we = 1'b1; end
      endcase
      step("EX", e, 6'($urandom), 6'($urandom), z, 1'($urandom), 1'b0);

      if (k == K_LW || k == K_SW) begin
         for (int m = 1; m <= n_mem; m++) begin
            last = (m == n_mem);
            rs = (m == rst_mem);
            e = '0; e.st = 3'd3; e.mem_req = 1'b1;
            e.wmem = (k == K_SW);
            e.pc_we = (k == K_SW) && last && !rs;
            step(rs ? "MEM_RST" : "MEM", e, 6'($urandom), 6'($urandom), 1'($urandom),
                 last | rs, rs);
            if (rs) begin
               e = '0;
               step("POST_RST", e, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
               return;
            end
         end
      end

      if (k == K_ALU || k == K_LW) begin
         e = '0; e.st = 3'd4; e.wreg = 1'b1; e.pc_we = 1'b1;
         e.regrt = en.regrt; e.mtoreg = (k == K_LW);
         step("WB", e, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
   endtask

   initial begin
      logic [5:0] rop, rfn;
      int         ri;
      add_ent(6'h00, 6'h20, K_ALU, 4'b0000, 0, 0, 0, 0);
      add_ent(6'h00, 6'h22, K_ALU, 4'b0100, 0, 0, 0, 0);
      add_ent(6'h00, 6'h24, K_ALU, 4'b0001, 0, 0, 0, 0);
      add_ent(6'h00, 6'h25, K_ALU, 4'b0101, 0, 0, 0, 0);
      add_ent(6'h00, 6'h26, K_ALU, 4'b0010, 0, 0, 0, 0);
      add_ent(6'h00, 6'h00, K_ALU, 4'b0011, 0, 1, 0, 0);
      add_ent(6'h00, 6'h02, K_ALU, 4'b0111, 0, 1, 0, 0);
      add_ent(6'h00, 6'h03, K_ALU, 4'b1111, 0, 1, 0, 0);
      add_ent(6'h00, 6'h08, K_JR,  4'b0000, 0, 0, 0, 0);
      add_ent(6'h08, 6'h00, K_ALU, 4'b0000, 1, 0, 1, 1);
      add_ent(6'h0C, 6'h00, K_ALU, 4'b0001, 1, 0, 0, 1);
      add_ent(6'h0D, 6'h00, K_ALU, 4'b0101, 1, 0, 0, 1);
      add_ent(6'h0E, 6'h00, K_ALU, 4'b0010, 1, 0, 0, 1);
      add_ent(6'h0F, 6'h00, K_ALU, 4'b0110, 1, 0, 0, 1);
      add_ent(6'h23, 6'h00, K_LW,  4'b0000, 1, 0, 1, 1);
      add_ent(6'h2B, 6'h00, K_SW,  4'b0000, 1, 0, 1, 0);
      add_ent(6'h04, 6'h00, K_BR,  4'b0000, 0, 0, 0, 0);
      add_ent(6'h05, 6'h00, K_BR,  4'b0000, 0, 0, 0, 0);
      add_ent(6'h02, 6'h00, K_J,   4'b0000, 0, 0, 0, 0);
      add_ent(6'h03, 6'h00, K_JAL, 4'b0000, 0, 0, 0, 0);

      bus_if.op = 6'h00; bus_if.func = 6'h00; bus_if.zero = 1'b0; bus_if.mem_ack = 1'b1;
      step("RST0", '0, 6'h23, 6'h20, 1'b1, 1'b1, 1'b1);
      step("RST1", '0, 6'h23, 6'h20, 1'b1, 1'b1, 1'b0);

      run_instr(6'h00, 6'h20, 1'b0, 1, 0);   // add
      run_instr(6'h04, 6'h00, 1'b1, 1, 0);   // beq taken
      run_instr(6'h04, 6'h00, 1'b0, 1, 0);   // beq not taken
      run_instr(6'h05, 6'h00, 1'b0, 1, 0);   // bne taken
      run_instr(6'h23, 6'h00, 1'b0, 3, 0);   // lw, ack on 3rd MEM cycle
      run_instr(6'h03, 6'h00, 1'b0, 1, 0);   // jal
      run_instr(6'h2B, 6'h00, 1'b0, 4, 0);   // sw
      run_instr(6'h2B, 6'h00, 1'b0, 5, 2);   // sw, reset on 2nd MEM cycle
      run_instr(6'h3F, 6'h15, 1'b0, 1, 0);   // illegal opcode
      run_instr(6'h00, 6'h3F, 1'b0, 1, 0);   // illegal func
      run_instr(6'h00, 6'h08, 1'b1, 1, 0);   // jr

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            ri  = $urandom_range(0, tbl.size() - 1);
            rop = tbl[ri].op;
            rfn = (rop == 6'h00) ? tbl[ri].func : 6'($urandom);
         end else begin
            rop = 6'($urandom);
            rfn = 6'($urandom);
         end
         run_instr(rop, rfn, 1'($urandom), $urandom_range(1, 4), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
